// File: rtl/regfile_debug_loader_if.sv
// Debug write/readback port between the switch loader and the regfile write-port mux,
// including the core stall handshake.
interface regfile_debug_loader_if;
   logic        stall_req;
   logic        stall_ack;
   logic        dbg_we;
   logic [4:0]  dbg_wa;
   logic [31:0] dbg_wd;
   logic [4:0]  dbg_ra;
   logic [31:0] dbg_rd;

   modport master (
      output stall_req, dbg_we, dbg_wa, dbg_wd, dbg_ra,
      input  stall_ack, dbg_rd
   );

   modport slave (
      input  stall_req, dbg_we, dbg_wa, dbg_wd, dbg_ra,
      output stall_ack, dbg_rd
   );
endinterface

// File: rtl/regfile_debug_loader.sv
// Switch-driven register file loader: shifts hex nibbles into a word, stalls the core, writes it.
// Define REGFILE_LOADER_READBACK_EN to add a VERIFY state that reads the register back and compares.
module regfile_debug_loader #(
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned ACK_TIMEOUT     = 1024
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [3:0]                    sw_nibble,
   input  logic [4:0]                    sw_addr,
   input  logic                          key_load_n,
   input  logic                          key_commit_n,
   regfile_debug_loader_if.master        dbg,
   output logic [31:0]                   word,
   output logic [3:0]                    nib_cnt,
   output logic                          busy,
   output logic                          err
);

   localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned ToW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [DbW-1:0] DbMax = DbW'(DEBOUNCE_CYCLES - 1);
   localparam logic [ToW-1:0] ToMax = ToW'(ACK_TIMEOUT - 1);

   typedef enum logic [2:0] {StIdle, StReq, StWrite, StVerify, StRelease} state_e;

   // Bit 1 = commit key, bit 0 = load key; all active-low at the pins.
   logic [1:0]     keys;
   logic [1:0]     sync1_q, sync2_q, stable_q, press_q;
   logic [DbW-1:0] db_cnt_q [2];

   state_e         state_q, state_d;
   logic [4:0]     addr_q, addr_d;
   logic [ToW-1:0] to_cnt_q, to_cnt_d;
   logic [31:0]    word_q, word_d;
   logic [3:0]     nib_q, nib_d;
   logic           err_q, err_d;
   logic           abort_q, abort_d;
   logic           commit_pls, load_pls;

   assign keys = {key_commit_n, key_load_n};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q  <= 2'b11;
         sync2_q  <= 2'b11;
         stable_q <= 2'b11;
         press_q  <= 2'b00;
         for (int k = 0; k < 2; k++) db_cnt_q[k] <= '0;
      end else begin
         sync1_q <= keys;
         sync2_q <= sync1_q;
         press_q <= 2'b00;
         for (int k = 0; k < 2; k++) begin
            if (sync2_q[k] == stable_q[k]) begin
               db_cnt_q[k] <= '0;
            end else if (db_cnt_q[k] == DbMax) begin
               db_cnt_q[k] <= '0;
               stable_q[k] <= sync2_q[k];
               press_q[k]  <= ~sync2_q[k];
            end else begin
               db_cnt_q[k] <= db_cnt_q[k] + 1'b1;
            end
         end
      end
   end

   assign commit_pls = press_q[1];
   assign load_pls   = press_q[0] & ~press_q[1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= StIdle;
         addr_q   <= '0;
         to_cnt_q <= '0;
         word_q   <= '0;
         nib_q    <= '0;
         err_q    <= 1'b0;
         abort_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         to_cnt_q <= to_cnt_d;
         word_q   <= word_d;
         nib_q    <= nib_d;
         err_q    <= err_d;
         abort_q  <= abort_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      to_cnt_d      = to_cnt_q;
      word_d        = word_q;
      nib_d         = nib_q;
      err_d         = err_q;
      abort_d       = abort_q;
      dbg.stall_req = 1'b0;
      dbg.dbg_we    = 1'b0;
      dbg.dbg_wa    = '0;
      dbg.dbg_wd    = '0;
      dbg.dbg_ra    = '0;
      unique case (state_q)
         StIdle: begin
            to_cnt_d = '0;
            abort_d  = 1'b0;
            if (commit_pls) begin
               addr_d = sw_addr;
               if (sw_addr >= 5'd2 && sw_addr <= 5'd25) state_d = StReq;
               else                                     err_d   = 1'b1;
            end else if (load_pls) begin
               word_d = {word_q[27:0], sw_nibble};
               if (nib_q != 4'd8) nib_d = nib_q + 4'd1;
            end
         end
         StReq: begin
            dbg.stall_req = 1'b1;
            if (dbg.stall_ack) begin
               state_d = StWrite;
            end else if (to_cnt_q == ToMax) begin
               err_d   = 1'b1;
               abort_d = 1'b1;
               state_d = StRelease;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         StWrite: begin
            dbg.stall_req = 1'b1;
            dbg.dbg_we    = 1'b1;
            dbg.dbg_wa    = addr_q;
            dbg.dbg_wd    = word_q;
            if (!dbg.stall_ack) err_d = 1'b1;
`ifdef REGFILE_LOADER_READBACK_EN
            state_d = StVerify;
`else
            state_d = StRelease;
`endif
         end
         StVerify: begin
`ifdef REGFILE_LOADER_READBACK_EN
            dbg.stall_req = 1'b1;
            dbg.dbg_ra    = addr_q;
            if (dbg.dbg_rd != word_q || !dbg.stall_ack) err_d = 1'b1;
`endif
            state_d = StRelease;
         end
         StRelease: begin
            // Hold here until the core has actually let go of the writeback port.
            if (!dbg.stall_ack) begin
               state_d = StIdle;
               if (!abort_q) begin
                  word_d = '0;
                  nib_d  = '0;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

`ifndef REGFILE_LOADER_READBACK_EN
   logic unused_rd;
   assign unused_rd = ^dbg.dbg_rd;
`endif

   assign word    = word_q;
   assign nib_cnt = nib_q;
   assign busy    = (state_q != StIdle);
   assign err     = err_q;

endmodule

// File: tb/tb_regfile_debug_loader.sv
// Randomized self-checking bench for regfile_debug_loader against a nibble-shift/commit model.
module tb_regfile_debug_loader;
   localparam int unsigned DEB = 4;
   localparam int unsigned TO  = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  sw_nibble;
   logic [4:0]  sw_addr;
   logic        key_load_n, key_commit_n;
   logic [31:0] word;
   logic [3:0]  nib_cnt;
   logic        busy, err;

   regfile_debug_loader_if bus ();

   regfile_debug_loader #(.DEBOUNCE_CYCLES(DEB), .ACK_TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .sw_nibble(sw_nibble), .sw_addr(sw_addr),
      .key_load_n(key_load_n), .key_commit_n(key_commit_n), .dbg(bus),
      .word(word), .nib_cnt(nib_cnt), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   // Core-side environment: register file and optional forced readback.
   logic [31:0] rf [32];
   logic        force_rd;
   logic [31:0] force_val;
   assign bus.dbg_rd = force_rd ? force_val : rf[bus.dbg_ra];

   int n_cmp = 0, n_bad = 0;
   int we_cnt, req_cycles, req_run, ack_delay;
   bit ack_on, ra_bad;
   logic [4:0]  cap_wa;
   logic [31:0] cap_wd;

   // Reference model
   logic [31:0] m_word;
   int          m_cnt;
   bit          m_err;

   task automatic tick();
      @(negedge clk);
      if (bus.dbg_we === 1'b1) begin
         we_cnt++;
         cap_wa = bus.dbg_wa;
         cap_wd = bus.dbg_wd;
         rf[bus.dbg_wa] = bus.dbg_wd;
      end
      if (bus.stall_req === 1'b1) begin
         req_cycles++;
         req_run++;
      end else begin
         req_run = 0;
      end
      bus.stall_ack = ack_on && (bus.stall_req === 1'b1) && (req_run >= ack_delay);
`ifndef REGFILE_LOADER_READBACK_EN
      if (bus.dbg_ra !== 5'd0) ra_bad = 1'b1;
`endif
   endtask

   task automatic do_reset();
      key_load_n = 1'b1; key_commit_n = 1'b1;
      ack_on = 1'b0; bus.stall_ack = 1'b0; req_run = 0;
      @(negedge clk); reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      m_word = '0; m_cnt = 0; m_err = 1'b0;
   endtask

   task automatic press_load(input logic [3:0] n);
      sw_nibble = n; key_load_n = 1'b0;
      repeat (10) tick();
      key_load_n = 1'b1;
      repeat (10) tick();
      m_word = {m_word[27:0], n};
      if (m_cnt < 8) m_cnt++;
   endtask

   task automatic commit(input logic [4:0] a, input bit ack, input int dly);
      we_cnt = 0; req_cycles = 0; ack_on = ack; ack_delay = dly;
      sw_addr = a; key_commit_n = 1'b0;
      repeat (10) tick();
      key_commit_n = 1'b1;
      repeat (40) tick();
      if (a >= 2 && a <= 25 && ack) begin
         m_word = '0; m_cnt = 0;
      end else begin
         m_err = 1'b1;
      end
   endtask

   task automatic test_reset();
      logic [81:0] v;
      v = {bus.stall_req, bus.dbg_we, bus.dbg_wa, bus.dbg_wd, bus.dbg_ra, word, nib_cnt, busy, err};
      n_cmp++; if (v !== '0) begin n_bad++; $display("FAIL reset_state: got %h want 0", v); end
   endtask

   task automatic test_basic();
      for (int i = 1; i <= 8; i++) press_load(4'(i));
      n_cmp++; if (word !== 32'h12345678) begin n_bad++; $display("FAIL load8_word: got %h want 12345678", word); end
      n_cmp++; if (nib_cnt !== 4'd8) begin n_bad++; $display("FAIL load8_cnt: got %0d want 8", nib_cnt); end
      commit(5'd5, 1'b1, 2);
      n_cmp++; if (we_cnt !== 1) begin n_bad++; $display("FAIL basic_we_cnt: got %0d want 1", we_cnt); end
      n_cmp++; if (cap_wa !== 5'd5) begin n_bad++; $display("FAIL basic_wa: got %0d want 5", cap_wa); end
      n_cmp++; if (cap_wd !== 32'h12345678) begin n_bad++; $display("FAIL basic_wd: got %h want 12345678", cap_wd); end
      n_cmp++; if ({word, nib_cnt, busy, err} !== '0) begin n_bad++; $display("FAIL basic_after: got word=%h cnt=%0d busy=%b err=%b want all 0", word, nib_cnt, busy, err); end
   endtask

   task automatic test_random();
      for (int it = 0; it < 6; it++) begin
         int n, dly;
         logic [4:0]  a;
         logic [31:0] exp_wd;
         n = $urandom_range(1, 10);
         for (int j = 0; j < n; j++) press_load(4'($urandom_range(0, 15)));
         n_cmp++; if (word !== m_word || nib_cnt !== 4'(m_cnt)) begin n_bad++; $display("FAIL rand_load: got %h/%0d want %h/%0d", word, nib_cnt, m_word, m_cnt); end
         exp_wd = m_word;
         a = 5'($urandom_range(2, 25));
         dly = $urandom_range(1, 5);
         commit(a, 1'b1, dly);
         n_cmp++; if (we_cnt !== 1 || cap_wa !== a || cap_wd !== exp_wd) begin n_bad++; $display("FAIL rand_write: got n=%0d wa=%0d wd=%h want n=1 wa=%0d wd=%h", we_cnt, cap_wa, cap_wd, a, exp_wd); end
         n_cmp++; if (word !== m_word || nib_cnt !== 4'(m_cnt) || err !== m_err || busy !== 1'b0) begin n_bad++; $display("FAIL rand_after: got %h/%0d err=%b busy=%b want %h/%0d err=%b", word, nib_cnt, err, busy, m_word, m_cnt, m_err); end
      end
   endtask

   task automatic test_busy_load();
      int t;
      press_load(4'hA);
      press_load(4'hB);
      we_cnt = 0; ack_on = 1'b1; ack_delay = 14;
      sw_addr = 5'd2; key_commit_n = 1'b0;
      t = 0;
      while (busy !== 1'b1 && t < 20) begin tick(); t++; end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_start: got busy=%b want 1", busy); end
      key_commit_n = 1'b1; sw_nibble = 4'hF; key_load_n = 1'b0;
      repeat (10) tick();
      n_cmp++; if (busy !== 1'b1 || word !== 32'h000000AB) begin n_bad++; $display("FAIL busy_load_drop: got busy=%b word=%h want 1 000000ab", busy, word); end
      key_load_n = 1'b1;
      repeat (40) tick();
      m_word = '0; m_cnt = 0;
      n_cmp++; if (we_cnt !== 1 || cap_wa !== 5'd2 || cap_wd !== 32'h000000AB) begin n_bad++; $display("FAIL ab_write: got n=%0d wa=%0d wd=%h want 1 2 000000ab", we_cnt, cap_wa, cap_wd); end
      n_cmp++; if (word !== 32'h0 || nib_cnt !== 4'd0 || busy !== 1'b0) begin n_bad++; $display("FAIL ab_after: got %h/%0d busy=%b want 0/0/0", word, nib_cnt, busy); end
   endtask

   task automatic test_illegal_addr();
      commit(5'd0, 1'b1, 1);
      n_cmp++; if (we_cnt !== 0 || req_cycles !== 0 || err !== 1'b1) begin n_bad++; $display("FAIL illegal0: got we=%0d req=%0d err=%b want 0 0 1", we_cnt, req_cycles, err); end
      commit(5'd27, 1'b1, 1);
      n_cmp++; if (we_cnt !== 0 || req_cycles !== 0 || err !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL illegal27: got we=%0d req=%0d err=%b busy=%b want 0 0 1 0", we_cnt, req_cycles, err, busy); end
   endtask

   task automatic test_commit_wins();
      press_load(4'h7);
      we_cnt = 0; req_cycles = 0;
      sw_nibble = 4'h9; sw_addr = 5'd30;
      key_load_n = 1'b0; key_commit_n = 1'b0;
      repeat (10) tick();
      key_load_n = 1'b1; key_commit_n = 1'b1;
      repeat (20) tick();
      n_cmp++; if (word !== m_word || nib_cnt !== 4'(m_cnt)) begin n_bad++; $display("FAIL commit_wins: got %h/%0d want %h/%0d", word, nib_cnt, m_word, m_cnt); end
      n_cmp++; if (we_cnt !== 0 || req_cycles !== 0) begin n_bad++; $display("FAIL commit_wins_bus: got we=%0d req=%0d want 0 0", we_cnt, req_cycles); end
   endtask

   task automatic test_timeout();
      press_load(4'hC);
      press_load(4'hD);
      commit(5'd9, 1'b0, 0);
      n_cmp++; if (req_cycles !== TO) begin n_bad++; $display("FAIL timeout_len: got %0d want %0d", req_cycles, TO); end
      n_cmp++; if (we_cnt !== 0 || err !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL timeout_flags: got we=%0d err=%b busy=%b want 0 1 0", we_cnt, err, busy); end
      n_cmp++; if (word !== 32'h000000CD || nib_cnt !== 4'd2) begin n_bad++; $display("FAIL timeout_keep: got %h/%0d want 000000cd/2", word, nib_cnt); end
   endtask

   task automatic test_reset_midflight();
      logic [81:0] v;
      int t;
      for (int pass = 0; pass < 2; pass++) begin
         do_reset();
         press_load(4'(5 + pass));
         ack_on = (pass == 1); ack_delay = 1; we_cnt = 0;
         sw_addr = 5'd4; key_commit_n = 1'b0;
         t = 0;
         while (((pass == 0) ? bus.stall_req : bus.dbg_we) !== 1'b1 && t < 30) begin tick(); t++; end
         n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL midflight_reach%0d: got busy=%b want 1", pass, busy); end
         key_commit_n = 1'b1;
         #2 reset = 1'b0;
         #1 v = {bus.stall_req, bus.dbg_we, bus.dbg_wa, bus.dbg_wd, bus.dbg_ra, word, nib_cnt, busy, err};
         n_cmp++; if (v !== '0) begin n_bad++; $display("FAIL reset_in_flight%0d: got %h want 0", pass, v); end
         ack_on = 1'b0; bus.stall_ack = 1'b0; req_run = 0;
         @(negedge clk); reset = 1'b1;
         m_word = '0; m_cnt = 0; m_err = 1'b0;
      end
   endtask

   task automatic test_readback();
`ifdef REGFILE_LOADER_READBACK_EN
      do_reset();
      press_load(4'h1);
      force_rd = 1'b1; force_val = 32'hDEADBEEF;
      commit(5'd7, 1'b1, 2);
      force_rd = 1'b0;
      n_cmp++; if (we_cnt !== 1 || err !== 1'b1) begin n_bad++; $display("FAIL rb_mismatch: got we=%0d err=%b want 1 1", we_cnt, err); end
      do_reset();
      press_load(4'h1);
      commit(5'd8, 1'b1, 2);
      n_cmp++; if (we_cnt !== 1 || err !== 1'b0) begin n_bad++; $display("FAIL rb_match: got we=%0d err=%b want 1 0", we_cnt, err); end
`else
      n_cmp++; if (ra_bad !== 1'b0) begin n_bad++; $display("FAIL ra_tied: got dbg_ra nonzero want 0"); end
`endif
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = '0;
      force_rd = 1'b0; force_val = '0; ra_bad = 1'b0;
      sw_nibble = '0; sw_addr = '0;
      key_load_n = 1'b1; key_commit_n = 1'b1;
      bus.stall_ack = 1'b0; ack_on = 1'b0; ack_delay = 0; req_run = 0;
      we_cnt = 0; req_cycles = 0; cap_wa = '0; cap_wd = '0;
      reset = 1'b0;
      m_word = '0; m_cnt = 0; m_err = 1'b0;
      repeat (3) @(negedge clk);
      test_reset();
      reset = 1'b1;
      test_basic();
      test_random();
      test_busy_load();
      test_illegal_addr();
      test_commit_wins();
      do_reset();
      test_timeout();
      test_reset_midflight();
      test_readback();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no completion want finish before time limit");
      $fatal(1, "watchdog expired");
   end
endmodule
